// File: rtl/seq_detect_ctrl.sv
// Measurement-window controller for the serial run-length sequence detector.
// Optional early stop on reaching the hit threshold: define SEQ_DETECT_CTRL_EARLY_STOP_EN.
module seq_detect_ctrl #(
   parameter int WIN_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             nRESET,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] win_len,
   input  logic [CNT_W-1:0] hit_thresh,
   input  logic             det_hit,
   output logic             det_en,
   output logic             det_clr,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [WIN_W-1:0] sample_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      CLEAR = 2'b01,
      RUN   = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t           state;
   logic [WIN_W-1:0] win_len_q;
   logic [CNT_W-1:0] hit_thresh_q;
   logic [CNT_W-1:0] hit_nxt;
   logic             last_sample;
   logic             early_stop;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      hit_nxt = hit_cnt;
      if (det_hit && (hit_cnt != {CNT_W{1'b1}}))
         hit_nxt = hit_cnt + CNT_W'(1);
      last_sample = (sample_cnt == (win_len_q - WIN_W'(1)));
`ifdef SEQ_DETECT_CTRL_EARLY_STOP_EN
      early_stop = (hit_thresh_q != '0) && (hit_nxt >= hit_thresh_q);
`else
      early_stop = 1'b0;
`endif
   end

   // Decoding straight from state lets det_en fall the moment reset asserts.
   assign det_clr = (state == CLEAR);
   assign det_en  = (state == RUN);
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments only, with the async reset in the sensitivity list.
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state        <= IDLE;
         win_len_q    <= '0;
         hit_thresh_q <= '0;
         hit_cnt      <= '0;
         sample_cnt   <= '0;
         pass         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  win_len_q    <= win_len;
                  hit_thresh_q <= hit_thresh;
                  hit_cnt      <= '0;
                  sample_cnt   <= '0;
                  state        <= CLEAR;
               end
            end
            CLEAR: begin
               if (abort) begin
                  state <= IDLE;
               end else if (win_len_q == '0) begin
                  pass  <= (hit_thresh_q == '0);
                  state <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  sample_cnt <= sample_cnt + WIN_W'(1);
                  hit_cnt    <= hit_nxt;
                  // The final sample's hit is already folded into hit_nxt.
                  if (last_sample || early_stop) begin
                     pass  <= (hit_nxt >= hit_thresh_q);
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed windows plus randomized hit
// patterns compared against a window-level reference model.
module tb_seq_detect_ctrl;
   localparam int WIN_W = 16;
   localparam int CNT_W = 8;
   localparam int MAX_LEN = 300;

   logic             clk = 1'b0;
   logic             nRESET;
   logic             start, abort, det_hit;
   logic [WIN_W-1:0] win_len;
   logic [CNT_W-1:0] hit_thresh;
   logic             det_en, det_clr, busy, done, pass;
   logic [CNT_W-1:0] hit_cnt;
   logic [WIN_W-1:0] sample_cnt;

   int   checks = 0;
   int   errors = 0;
   logic pat [0:MAX_LEN-1];
   logic exp_pass;

   seq_detect_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .nRESET     (nRESET),
      .start      (start),
      .abort      (abort),
      .win_len    (win_len),
      .hit_thresh (hit_thresh),
      .det_hit    (det_hit),
      .det_en     (det_en),
      .det_clr    (det_clr),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .hit_cnt    (hit_cnt),
      .sample_cnt (sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_pat();
      for (int i = 0; i < MAX_LEN; i++) pat[i] = 1'b0;
   endtask

   task automatic rand_pat(input int pct);
      for (int i = 0; i < MAX_LEN; i++) pat[i] = ($urandom_range(0, 99) < pct);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_det_en"}, det_en, 0);
      check({tag, "_det_clr"}, det_clr, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_pass"}, pass, 0);
      check({tag, "_hit_cnt"}, hit_cnt, 0);
      check({tag, "_sample_cnt"}, sample_cnt, 0);
   endtask

   // Model works on the whole window: count hits in pat, saturate, compare with threshold.
   task automatic run_window(input int len, input int thr, input string tag);
      int   run_n, hits;
      logic ep;
      hits  = 0;
      run_n = len;
      for (int i = 0; i < len; i++) begin
         if (pat[i]) hits++;
`ifdef SEQ_DETECT_CTRL_EARLY_STOP_EN
         if (thr != 0 && hits >= thr) begin
            run_n = i + 1;
            break;
         end
`endif
      end
      if (hits > 255) hits = 255;
      ep = (hits >= thr);

      // start and abort together in IDLE: start wins
      start = 1'b1; abort = 1'b1; win_len = WIN_W'(len); hit_thresh = CNT_W'(thr); det_hit = 1'b0;
      cyc();
      start = 1'b0; abort = 1'b0; det_hit = 1'b1;
      check({tag, "_clr"}, det_clr, 1);
      check({tag, "_clr_en"}, det_en, 0);
      check({tag, "_clr_busy"}, busy, 1);
      check({tag, "_clr_done"}, done, 0);
      win_len = WIN_W'($urandom); hit_thresh = CNT_W'($urandom);
      cyc();
      for (int i = 0; i < run_n; i++) begin
         det_hit = pat[i];
         start   = 1'($urandom_range(0, 1));
         check({tag, "_run_en"}, det_en, 1);
         check({tag, "_run_done"}, done, 0);
         if (i == 0) check({tag, "_run_clr"}, det_clr, 0);
         cyc();
      end
      start = 1'b0; abort = 1'($urandom_range(0, 1)); det_hit = 1'($urandom_range(0, 1));
      check({tag, "_done"}, done, 1);
      check({tag, "_done_en"}, det_en, 0);
      check({tag, "_hit_cnt"}, hit_cnt, hits);
      check({tag, "_sample_cnt"}, sample_cnt, run_n);
      check({tag, "_pass"}, pass, ep);
      cyc();
      abort = 1'b0; det_hit = 1'b0;
      check({tag, "_post_done"}, done, 0);
      check({tag, "_post_busy"}, busy, 0);
      check({tag, "_post_pass"}, pass, ep);
      check({tag, "_post_hits"}, hit_cnt, hits);
      exp_pass = ep;
   endtask

   initial begin
      nRESET = 1'b0; start = 1'b0; abort = 1'b0; det_hit = 1'b0;
      win_len = '0; hit_thresh = '0; exp_pass = 1'b0;
      cyc();
      check_idle_zero("reset");
      nRESET = 1'b1;
      cyc();

      // win_len=8, thresh=2, hits in RUN cycles 3, 5, 8
      clear_pat();
      pat[2] = 1'b1; pat[4] = 1'b1; pat[7] = 1'b1;
      run_window(8, 2, "w8");

      // win_len=5, thresh=3, one hit: fail, and pass stays low in IDLE
      clear_pat();
      pat[1] = 1'b1;
      run_window(5, 3, "w5");
      repeat (3) cyc();
      check("w5_idle_pass", pass, 0);

      // Passing window, then abort in RUN cycle 2 of win_len=6
      clear_pat();
      run_window(3, 0, "w3");
      start = 1'b1; win_len = 16'd6; hit_thresh = 8'd1;
      cyc();
      start = 1'b0;
      cyc();
      det_hit = 1'b1;
      cyc();
      abort = 1'b1;
      check("abort_run_en", det_en, 1);
      cyc();
      abort = 1'b0; det_hit = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_en", det_en, 0);
      check("abort_pass", pass, exp_pass);
      rand_pat(40);
      run_window(4, 1, "after_abort");

      // Reset mid-RUN after 4 samples of a 10-sample window
      clear_pat();
      run_window(2, 0, "pre_rst");
      start = 1'b1; win_len = 16'd10; hit_thresh = 8'd0;
      cyc();
      start = 1'b0; det_hit = 1'b1;
      cyc();
      repeat (4) cyc();
      check("rst_pre_en", det_en, 1);
      nRESET = 1'b0;
      #1;
      check_idle_zero("rst_mid");
      det_hit = 1'b0;
      cyc();
      nRESET = 1'b1;
      cyc();
      check("rst_idle_done", done, 0);
      rand_pat(50);
      run_window(10, 3, "after_rst");

      // Zero-length windows
      run_window(0, 0, "w0_t0");
      run_window(0, 1, "w0_t1");

      // Saturation: det_hit held high for 300 samples
      for (int i = 0; i < MAX_LEN; i++) pat[i] = 1'b1;
      run_window(300, 4, "sat");

      // Randomized windows
      for (int k = 0; k < 12; k++) begin
         rand_pat($urandom_range(0, 100));
         run_window($urandom_range(1, 20), $urandom_range(0, 6), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Measurement-window controller for the serial run-length sequence detector.
- Arms the detector, clears its state, gates it for a programmed number of sample cycles and counts its detection pulses.
- Reports pass/fail against a hit threshold through a start/done handshake.
- Sits between the control/status logic and the detector: drives the detector's enable and clear, and consumes its output.

Parameters:
- WIN_W, 16, width of window length and sample counter.
- CNT_W, 8, width of hit threshold and hit counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- nRESET  input  1  asynchronous active-low reset
- start  input  1  begin a measurement window; sampled only in IDLE
- abort  input  1  cancel the active window
- win_len  input  WIN_W  window length in sample cycles; latched on accepted start
- hit_thresh  input  CNT_W  minimum hits for pass; latched on accepted start
- det_hit  input  1  detector output (Mealy, one pulse per detection cycle)
- det_en  output  1  detector sampling enable
- det_clr  output  1  detector state clear, forces detector to start state
- busy  output  1  high in CLEAR, RUN and DONE
- done  output  1  one-cycle completion pulse
- pass  output  1  result of last completed window
- hit_cnt  output  CNT_W  hits counted in current/last window
- sample_cnt  output  WIN_W  samples taken in current/last window

Behaviour:
- Reset (async, nRESET=0): state=IDLE; det_en=0, det_clr=0, busy=0, done=0, pass=0, hit_cnt=0, sample_cnt=0; latched win_len/hit_thresh=0.
- States: IDLE=2'b00, CLEAR=2'b01, RUN=2'b10, DONE=2'b11. Encoding is registered; the output decode is combinational from state.
- IDLE:
  - start=1 latches win_len and hit_thresh, zeroes hit_cnt and sample_cnt, and moves to CLEAR.
  - pass holds its last value.
- CLEAR:
  - det_clr=1 for exactly one cycle; det_en=0.
  - abort=1 goes to IDLE.
  - Otherwise, latched win_len=0 goes to DONE; any other value goes to RUN.
- RUN:
  - det_en=1 every cycle.
  - Each cycle sample_cnt increments by 1.
  - det_hit=1 increments hit_cnt, saturating at 2^CNT_W-1 with no wrap.
  - On the cycle where sample_cnt == win_len_q-1 (the last sample), move to DONE. A hit in that cycle is counted.
- DONE:
  - done=1 for one cycle, then IDLE.
  - pass is registered on the DONE entry edge as (final hit_cnt >= hit_thresh_q), including the last-cycle hit, and is valid while done=1.
  - pass holds until the next DONE or reset.
  - hit_cnt and sample_cnt hold until the next accepted start.
- Latency: start accepted at edge N; det_clr high in cycle N+1; RUN cycles N+2..N+1+win_len; done high in cycle N+2+win_len.
- det_hit outside RUN is ignored.
- start while busy is ignored; no queuing.
- abort:
  - Honoured in CLEAR and RUN, with priority over completion in the same cycle.
  - Goes to IDLE next edge with no done pulse; pass is unchanged; counters keep partial values.
  - abort in IDLE or DONE has no effect; the DONE pulse still completes.
- start and abort together in IDLE: start wins; abort applies from CLEAR onward.
- win_len=0: no RUN cycles; done follows CLEAR directly; hit_cnt=0; pass = (hit_thresh_q==0).
- hit_thresh=0: pass=1 on every completed window.
- Reset mid-window: immediate return to IDLE with all outputs at reset values; det_en drops asynchronously.
- Input changes to win_len/hit_thresh while busy have no effect.

Optional Feature:
- Macro: SEQ_DETECT_CTRL_EARLY_STOP_EN.
- Defined:
  - In RUN, the cycle in which the incremented hit count reaches hit_thresh_q (nonzero threshold) goes to DONE with pass=1.
  - sample_cnt shows samples actually taken.
  - abort keeps priority.
- Undefined: the window always runs the full win_len samples; the early-stop logic is absent.

Test Plan:
- Reset mid-RUN (win_len=10, after 4 samples): all outputs 0 immediately; no done; next start runs normally.
- win_len=8, hit_thresh=2, det_hit high in RUN cycles 3, 5 and 8 (1-based):
  - det_clr in cycle 1 after start, det_en for 8 cycles.
  - done 10 cycles after the start edge, hit_cnt=3, sample_cnt=8, pass=1.
  - Without the macro, the full 8 samples run.
- win_len=5, hit_thresh=3, one hit: done with hit_cnt=1, pass=0; pass stays 0 through IDLE.
- abort in RUN cycle 2 of win_len=6: IDLE next cycle; no done; pass keeps prior value; busy=0; a new start is accepted the following cycle.
- win_len=0 with thresh=0, then thresh=1: done 2 cycles after start, det_en never high; pass=1, then pass=0.
- det_hit held high for 300 samples with CNT_W=8: hit_cnt saturates at 255. With the macro and hit_thresh=4: done after 4 samples, sample_cnt=4, pass=1.
